// File: rtl/inst_decoder_if.sv
// inst_decoder_if: host-facing bundle for the core instruction decoder.
// The host (master) drives the 47-bit instruction word and the OFIFO
// valid flag. The decoder (slave) returns the registered control strobes,
// the current pass phase and the checker status.
interface inst_decoder_if;
    logic [46:0] inst;
    logic        ofifo_valid;

    logic        cen_xmem, wen_xmem, cen_wmem, wen_wmem, cen_pmem, wen_pmem;
    logic [10:0] a_xmem, a_wmem, a_pmem;
    logic        acc, ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute, load;
    logic [2:0]  phase;
    logic [7:0]  err;
    logic        err_pulse;

    modport master (
        output inst, ofifo_valid,
        input  cen_xmem, wen_xmem, cen_wmem, wen_wmem, cen_pmem, wen_pmem,
        input  a_xmem, a_wmem, a_pmem,
        input  acc, ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute, load,
        input  phase, err, err_pulse
    );

    modport slave (
        input  inst, ofifo_valid,
        output cen_xmem, wen_xmem, cen_wmem, wen_wmem, cen_pmem, wen_pmem,
        output a_xmem, a_wmem, a_pmem,
        output acc, ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute, load,
        output phase, err, err_pulse
    );
endinterface

// File: rtl/inst_decoder.sv
// inst_decoder: registers the 47-bit instruction word, splits it into the
// SRAM / L0 / IFIFO / OFIFO / PE / SFU controls, tracks the pass phase and
// (optionally) runs an on-chip protocol checker with sticky error flags.
// Optional feature macro: INST_DECODER_CHECK_EN (error logic + run counter).
// Without it err/err_pulse are tied low; decode and phase FSM are unchanged.
module inst_decoder #(
    parameter int LEN_NIJ    = 36,
    parameter int ROW        = 8,
    parameter int COL        = 8,
    parameter int XMEM_DEPTH = 64,
    parameter int WMEM_DEPTH = 16,
    parameter int PMEM_DEPTH = 512
) (
    input  logic          clk,
    input  logic          reset,
    inst_decoder_if.slave bus
);
    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_WMEM_WR  = 3'd1,
        PH_IFIFO_WR = 3'd2,
        PH_LOAD     = 3'd3,
        PH_L0_WR    = 3'd4,
        PH_EXEC     = 3'd5,
        PH_OFIFO_RD = 3'd6,
        PH_ACC      = 3'd7
    } phase_t;

    // Reset word: all SRAMs deselected, addresses zero, strobes idle.
    localparam logic [46:0] INST_RST = {2'b11, 11'd0, 1'b0, 2'b11, 11'd0, 2'b11, 11'd0, 7'd0};

    logic [46:0] inst_q;
    logic [7:1]  grp;        // grp[n] set when command group Gn is active
    phase_t      phase_q, phase_d;

    // Command group membership of the incoming word
    always_comb begin
        grp    = '0;
        grp[1] = ~bus.inst[19] & ~bus.inst[18];
        grp[2] = bus.inst[5];
        grp[3] = bus.inst[4] | bus.inst[0];
        grp[4] = bus.inst[2];
        grp[5] = bus.inst[3] | bus.inst[1];
        grp[6] = bus.inst[6];
        grp[7] = bus.inst[33];
    end

    // Next phase: lowest-numbered active group wins, otherwise hold
    always_comb begin
        phase_d = phase_q;
        casez (grp)
            7'b??????1: phase_d = PH_WMEM_WR;
            7'b?????10: phase_d = PH_IFIFO_WR;
            7'b????100: phase_d = PH_LOAD;
            7'b???1000: phase_d = PH_L0_WR;
            7'b??10000: phase_d = PH_EXEC;
            7'b?100000: phase_d = PH_OFIFO_RD;
            7'b1000000: phase_d = PH_ACC;
            default:    phase_d = phase_q;
        endcase
    end

    // Phase state register
    always_ff @(posedge clk) begin
        if (reset) phase_q <= PH_IDLE;
        else       phase_q <= phase_d;
    end

    // Instruction word register; every decoded output is a slice of it
    always_ff @(posedge clk) begin
        if (reset) inst_q <= INST_RST;
        else       inst_q <= bus.inst;
    end

    assign bus.cen_xmem = inst_q[46];
    assign bus.wen_xmem = inst_q[45];
    assign bus.a_xmem   = inst_q[44:34];
    assign bus.acc      = inst_q[33];
    assign bus.cen_pmem = inst_q[32];
    assign bus.wen_pmem = inst_q[31];
    assign bus.a_pmem   = inst_q[30:20];
    assign bus.cen_wmem = inst_q[19];
    assign bus.wen_wmem = inst_q[18];
    assign bus.a_wmem   = inst_q[17:7];
    assign bus.ofifo_rd = inst_q[6];
    assign bus.ififo_wr = inst_q[5];
    assign bus.ififo_rd = inst_q[4];
    assign bus.l0_rd    = inst_q[3];
    assign bus.l0_wr    = inst_q[2];
    assign bus.execute  = inst_q[1];
    assign bus.load     = inst_q[0];
    assign bus.phase    = phase_q;

`ifdef INST_DECODER_CHECK_EN
    localparam int EXEC_MAX = LEN_NIJ + ROW + COL + 1;

    logic [7:0] grp_ext;     // grp re-indexed so grp_ext[phase] is that phase's group
    logic [7:0] err_q, err_new;
    logic [7:0] run_q, run_d;
    logic       err_pulse_q, phase_chg;

    function automatic logic legal_tr(input phase_t cur, input phase_t nxt);
        if (cur == PH_IDLE || nxt == cur) return 1'b1;
        if (cur == PH_OFIFO_RD)           return (nxt == PH_WMEM_WR) || (nxt == PH_ACC);
        if (cur == PH_ACC)                return 1'b0;
        return {1'b0, nxt} == ({1'b0, cur} + 4'd1);
    endfunction

    // Run counter and newly detected violations for this cycle
    always_comb begin
        grp_ext   = {grp, 1'b0};
        phase_chg = (phase_d != phase_q);   // only possible with a group active
        // The command that enters a phase is the first cycle of its run,
        // so a phase change restarts the count at one rather than zero.
        if (phase_chg)                              run_d = 8'd1;
        else if (grp_ext[phase_q] && run_q != 8'hFF) run_d = run_q + 8'd1;
        else                                        run_d = run_q;

        err_new    = '0;
        err_new[0] = ($countones(grp) > 1);
        err_new[1] = phase_chg && !legal_tr(phase_q, phase_d);
        err_new[2] = bus.inst[6] & ~bus.ofifo_valid;
        err_new[3] = bus.inst[6] & (bus.inst[32] | bus.inst[31]);
        err_new[4] = (~bus.inst[46] && 32'(bus.inst[44:34]) >= 32'(XMEM_DEPTH)) ||
                     (~bus.inst[19] && 32'(bus.inst[17:7])  >= 32'(WMEM_DEPTH)) ||
                     (~bus.inst[32] && 32'(bus.inst[30:20]) >= 32'(PMEM_DEPTH));
        err_new[5] = (phase_q == PH_OFIFO_RD) && phase_chg && (run_q != 8'(LEN_NIJ));
        err_new[6] = bus.inst[5] & ~bus.inst[18];
        err_new[7] = (phase_d == PH_EXEC) && (32'(run_d) > 32'(EXEC_MAX));
    end

    // Sticky error flags, one-cycle pulse on any newly set bit, run counter
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q       <= '0;
            err_pulse_q <= 1'b0;
            run_q       <= '0;
        end else begin
            err_q       <= err_q | err_new;
            err_pulse_q <= |(err_new & ~err_q);
            run_q       <= run_d;
        end
    end

    assign bus.err       = err_q;
    assign bus.err_pulse = err_pulse_q;
`else
    // Checker removed: inputs and limits it would consume are intentionally idle.
    logic unused_chk;
    assign unused_chk = ^{bus.ofifo_valid, LEN_NIJ[0], ROW[0], COL[0],
                          XMEM_DEPTH[0], WMEM_DEPTH[0], PMEM_DEPTH[0]};

    assign bus.err       = '0;
    assign bus.err_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_inst_decoder.sv
// tb_inst_decoder: drives instruction words through inst_decoder, keeps a
// reference model of decode, phase and checker state, and compares via a
// scoreboard queue one cycle after each word is applied.
module tb_inst_decoder;
    localparam int LEN_NIJ = 36;
    localparam int ROW     = 8;
    localparam int COL     = 8;
`ifdef INST_DECODER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [46:0] NOP    = {2'b11, 11'd0, 1'b0, 2'b11, 11'd0, 2'b11, 11'd0, 7'd0};
    localparam logic [6:0]  S_IFWR = 7'b0100000;
    localparam logic [6:0]  S_LOAD = 7'b0000001;
    localparam logic [6:0]  S_IFRD = 7'b0010000;
    localparam logic [6:0]  S_L0WR = 7'b0000100;
    localparam logic [6:0]  S_L0RD = 7'b0001000;
    localparam logic [6:0]  S_EXEC = 7'b0000010;
    localparam logic [6:0]  S_OFRD = 7'b1000000;

    logic clk = 1'b0;
    logic reset;

    inst_decoder_if bus();

    inst_decoder #(
        .LEN_NIJ(LEN_NIJ), .ROW(ROW), .COL(COL),
        .XMEM_DEPTH(64), .WMEM_DEPTH(16), .PMEM_DEPTH(512)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [46:0] word;
        logic [2:0]  ph;
        logic [7:0]  err;
        logic        pulse;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [2:0] m_phase;
    logic [7:0] m_run;
    logic [7:0] m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Pop the oldest expectation and compare it against the DUT outputs
    task automatic compare_out();
        exp_t        e;
        logic [46:0] dec;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: got 0 entries expected 1");
            return;
        end
        e   = sb.pop_front();
        dec = {bus.cen_xmem, bus.wen_xmem, bus.a_xmem, bus.acc, bus.cen_pmem, bus.wen_pmem,
               bus.a_pmem, bus.cen_wmem, bus.wen_wmem, bus.a_wmem, bus.ofifo_rd, bus.ififo_wr,
               bus.ififo_rd, bus.l0_rd, bus.l0_wr, bus.execute, bus.load};
        check({e.tag, "/dec"},   64'(dec),           64'(e.word));
        check({e.tag, "/phase"}, 64'(bus.phase),     64'(e.ph));
        check({e.tag, "/err"},   64'(bus.err),       64'(e.err));
        check({e.tag, "/pulse"}, 64'(bus.err_pulse), 64'(e.pulse));
        $display("[TB] %s inst=%h phase=%0d err=%02h pulse=%0b",
                 e.tag, e.word, bus.phase, bus.err, bus.err_pulse);
    endtask

    // Apply one word for one cycle, predict its effect, then check it
    task automatic step(input string tag, input logic [46:0] w, input logic ofv);
        logic [7:1] g;
        int         cnt;
        logic [2:0] nxt;
        logic [7:0] enew;
        logic [7:0] run_n;
        logic       ok;
        exp_t       e;

        @(negedge clk);
        reset           = 1'b0;
        bus.inst        = w;
        bus.ofifo_valid = ofv;

        g[1] = !w[19] && !w[18];
        g[2] = w[5];
        g[3] = w[4] || w[0];
        g[4] = w[2];
        g[5] = w[3] || w[1];
        g[6] = w[6];
        g[7] = w[33];
        cnt = 0;
        nxt = m_phase;
        for (int i = 7; i >= 1; i--) begin
            if (g[i]) begin
                cnt++;
                nxt = 3'(i);
            end
        end

        enew = '0;
        if (cnt > 1) enew[0] = 1'b1;
        ok = 1'b1;
        case (m_phase)
            3'd0:                         ok = 1'b1;
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5: ok = (nxt == m_phase) || (nxt == m_phase + 3'd1);
            3'd6:                         ok = (nxt == 3'd6) || (nxt == 3'd1) || (nxt == 3'd7);
            default:                      ok = (nxt == 3'd7);
        endcase
        if (!ok) enew[1] = 1'b1;
        if (w[6] && !ofv) enew[2] = 1'b1;
        if (w[6] && (w[32] || w[31])) enew[3] = 1'b1;
        if ((!w[46] && w[44:34] >= 11'd64) || (!w[19] && w[17:7] >= 11'd16) ||
            (!w[32] && w[30:20] >= 11'd512)) enew[4] = 1'b1;
        if (m_phase == 3'd6 && nxt != 3'd6 && m_run != 8'(LEN_NIJ)) enew[5] = 1'b1;
        if (w[5] && !w[18]) enew[6] = 1'b1;
        if (nxt != m_phase)                             run_n = 8'd1;
        else if (m_phase != 3'd0 && g[m_phase] && m_run != 8'hFF) run_n = m_run + 8'd1;
        else                                            run_n = m_run;
        if (nxt == 3'd5 && int'(run_n) > LEN_NIJ + ROW + COL + 1) enew[7] = 1'b1;

        e.pulse = CHK && (|(enew & ~m_err));
        m_err   = m_err | enew;
        m_phase = nxt;
        m_run   = run_n;
        e.tag   = tag;
        e.word  = w;
        e.ph    = nxt;
        e.err   = CHK ? m_err : 8'd0;
        sb.push_back(e);

        @(posedge clk);
        #1;
        compare_out();
    endtask

    // Reset with a random word on the bus: reset must win
    task automatic do_reset(input string tag);
        exp_t        e;
        logic [63:0] r;
        @(negedge clk);
        r               = {$urandom, $urandom};
        reset           = 1'b1;
        bus.inst        = r[46:0];
        bus.ofifo_valid = 1'b1;
        m_phase = '0;
        m_run   = '0;
        m_err   = '0;
        e.tag   = tag;
        e.word  = NOP;
        e.ph    = '0;
        e.err   = '0;
        e.pulse = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    function automatic logic [46:0] f_xmem(input logic [10:0] a);
        logic [46:0] w;
        w = NOP; w[46] = 1'b0; w[45] = 1'b0; w[44:34] = a;
        return w;
    endfunction

    function automatic logic [46:0] f_wmem(input logic [10:0] a);
        logic [46:0] w;
        w = NOP; w[19] = 1'b0; w[18] = 1'b0; w[17:7] = a;
        return w;
    endfunction

    function automatic logic [46:0] f_strb(input logic [6:0] s);
        logic [46:0] w;
        w = NOP; w[6:0] = s;
        return w;
    endfunction

    function automatic logic [46:0] f_ofrd(input logic [10:0] a);
        logic [46:0] w;
        w = NOP; w[6] = 1'b1; w[32] = 1'b0; w[31] = 1'b0; w[30:20] = a;
        return w;
    endfunction

    function automatic logic [46:0] f_acc();
        logic [46:0] w;
        w = NOP; w[33] = 1'b1;
        return w;
    endfunction

    initial begin
        logic [46:0] w;
        reset           = 1'b1;
        bus.inst        = NOP;
        bus.ofifo_valid = 1'b0;
        m_phase = '0;
        m_run   = '0;
        m_err   = '0;
        repeat (2) @(posedge clk);
        do_reset("rst");

        // Full kij pass, then the next kij starts (6 -> 1)
        for (int i = 0; i < 4; i++)  step("xmem", f_xmem(11'(i * 20)), 1'b0);
        for (int i = 0; i < 8; i++)  step("wmem", f_wmem(11'(i)), 1'b0);
        for (int i = 0; i < 9; i++)  step("ififo_wr", f_strb(S_IFWR), 1'b0);
        for (int i = 0; i < 16; i++) step("load", f_strb((i % 2) ? (S_LOAD | S_IFRD) : S_LOAD), 1'b0);
        for (int i = 0; i < 37; i++) step("l0_wr", f_strb(S_L0WR), 1'b0);
        for (int i = 0; i < 52; i++) step("exec", f_strb((i % 2) ? (S_EXEC | S_L0RD) : S_EXEC), 1'b0);
        for (int i = 0; i < 36; i++) step("ofifo_rd", f_ofrd(11'(100 + i)), 1'b1);
        step("next_kij", f_wmem(11'd3), 1'b0);

        // Two groups in one cycle, then clean traffic
        do_reset("rst_g");
        step("l0_wr", f_strb(S_L0WR), 1'b0);
        w = f_ofrd(11'd5); w[2] = 1'b1;
        step("multi_grp", w, 1'b1);
        for (int i = 0; i < 3; i++) step("l0_clean", f_strb(S_L0WR), 1'b0);

        // Illegal jump 3 -> 6
        do_reset("rst_t");
        for (int i = 0; i < 2; i++) step("load", f_strb(S_LOAD), 1'b0);
        step("jump3to6", f_ofrd(11'd7), 1'b1);

        // OFIFO run of exactly LEN_NIJ, then accumulate
        do_reset("rst_r36");
        for (int i = 0; i < 36; i++) step("ofrd36", f_ofrd(11'(i)), 1'b1);
        step("acc36", f_acc(), 1'b0);
        step("acc_hold", f_acc(), 1'b0);

        // OFIFO run one short
        do_reset("rst_r35");
        for (int i = 0; i < 35; i++) step("ofrd35", f_ofrd(11'(i)), 1'b1);
        step("acc35", f_acc(), 1'b0);

        // Address limits
        do_reset("rst_a");
        step("wmem15", f_wmem(11'd15), 1'b0);
        step("wmem16", f_wmem(11'd16), 1'b0);
        step("xmem64", f_xmem(11'd64), 1'b0);
        do_reset("rst_after_a");

        // Remaining checker bits: OFIFO empty, pmem not written, weight conflict
        step("ofrd_novalid", f_ofrd(11'd1), 1'b0);
        do_reset("rst_b");
        step("ofrd_nopmem", f_strb(S_OFRD), 1'b1);
        do_reset("rst_c");
        w = f_strb(S_IFWR); w[18] = 1'b0;
        step("ififo_wconf", w, 1'b0);

        // EXEC run one past its limit
        do_reset("rst_e");
        for (int i = 0; i < 54; i++) step("exec_long", f_strb(S_EXEC), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/inst_decoder.md
# inst_decoder

Core-side receiver for the 47-bit instruction word that the testbench or host drives into `core`. It registers the word and splits it into named control strobes for the SRAMs, L0, IFIFO, OFIFO, PE array and SFU. It tracks the current pass phase with a small state machine. It flags protocol violations in a sticky error register, so the datapath consumes clean one-cycle-delayed controls and verification gets an on-chip checker.

## Interface
- `LEN_NIJ`, 36, OFIFO-read run length per kij pass
- `ROW`, 8, PE rows
- `COL`, 8, PE columns
- `XMEM_DEPTH`, 64, valid activation SRAM words
- `WMEM_DEPTH`, 16, valid weight SRAM words
- `PMEM_DEPTH`, 512, valid psum SRAM words
- `clk`  input  1  clock; everything samples on posedge
- `reset`  input  1  synchronous, active-high
- `inst`  input  47  instruction word (field map below)
- `ofifo_valid`  input  1  OFIFO has data
- `cen_xmem, wen_xmem, cen_wmem, wen_wmem, cen_pmem, wen_pmem`  output  1 each  registered SRAM controls, active-low
- `a_xmem, a_wmem, a_pmem`  output  11 each  registered addresses
- `acc, ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute, load`  output  1 each  registered strobes
- `phase`  output  3  current phase
- `err`  output  8  sticky error flags
- `err_pulse`  output  1  high for one cycle when any err bit newly sets

Field map of `inst`:
- [46] CEN_xmem, [45] WEN_xmem, [44:34] A_xmem
- [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
- [19] CEN_wmem, [18] WEN_wmem, [17:7] A_wmem
- [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load

## Operation
- Decode: each output equals its `inst` field registered once. No combinational path from `inst` to any output.
- Command groups (mutually exclusive):
  - G1 = {CEN_wmem=0 & WEN_wmem=0}
  - G2 = ififo_wr
  - G3 = ififo_rd|load
  - G4 = l0_wr
  - G5 = l0_rd|execute
  - G6 = ofifo_rd
  - G7 = acc
- Activation writes (CEN_xmem=0, WEN_xmem=0) belong to no group. They are legal in any phase.
- Phase FSM encoding: IDLE=0, WMEM_WR=1, IFIFO_WR=2, LOAD=3, L0_WR=4, EXEC=5, OFIFO_RD=6, ACC=7.
- `phase` takes the lowest-numbered active group. A cycle with no group active holds `phase` unchanged.
- Legal transitions:
  - IDLE → any
  - a phase → itself
  - 1→2→3→4→5→6
  - 6→1 (next kij)
  - 6→7
  - 7→7
- Errors. Every bit is sticky until reset.
  - err[0]: more than one group active in the same cycle.
  - err[1]: illegal phase transition. `phase` still takes the new value.
  - err[2]: ofifo_rd=1 while ofifo_valid=0.
  - err[3]: ofifo_rd=1 without CEN_pmem=0 and WEN_pmem=0.
  - err[4]: an address is out of range while its CEN=0. Limits are A_xmem≥XMEM_DEPTH, A_wmem≥WMEM_DEPTH, A_pmem≥PMEM_DEPTH.
  - err[5]: an OFIFO_RD run length ≠ LEN_NIJ. Checked when the phase leaves OFIFO_RD.
  - err[6]: ififo_wr=1 while WEN_wmem=0 (read/write conflict on weight SRAM).
  - err[7]: an EXEC run exceeds LEN_NIJ+ROW+COL+1 consecutive cycles.
- Run counter: 8-bit, saturating. Cleared on phase change. Increments each cycle the current phase's group is active.

## Timing
- Reset values:
  - all CEN/WEN outputs = 1
  - addresses = 0
  - strobes = 0
  - `phase` = 0
  - `err` = 0
  - `err_pulse` = 0
  - run counter = 0
- Decoded outputs have 1-cycle latency: `inst` sampled at edge n appears on outputs after edge n.
- `phase` also updates at edge n. An `err` bit caused by `inst` at edge n is visible after edge n, with `err_pulse` high that same cycle.
- err[5] evaluates at the edge where the new phase is sampled.
- Reset mid-pass returns all state to reset values. The next phase is then checked as if coming from IDLE.
- Reset has priority over any simultaneous `inst`.

## Configuration
- `INST_DECODER_CHECK_EN` defined: the error logic and run counter are compiled in, as specified above.
- `INST_DECODER_CHECK_EN` undefined: the error logic and run counter are removed. `err` and `err_pulse` are tied to 0. Decode and the phase FSM are unchanged.

## Test plan
- Full kij pass, one cycle per command with the remaining runs as listed: 8 wmem writes, 9 ififo_wr, 16 load, 37 l0_wr, 52 execute, 36 ofifo_rd with pmem writes and ofifo_valid=1 → phase goes 1,2,3,4,5,6; err=0.
- Drive l0_wr=1 and ofifo_rd=1 in the same cycle → err[0]=1 and err_pulse=1 one cycle later; err holds after further clean traffic.
- Go from phase 3 directly to phase 6 → err[1]=1 and phase=6.
- 35 ofifo_rd cycles followed by acc → err[5]=1 at the acc edge. Separately, with 36 cycles → err[5]=0.
- A_wmem=16 with CEN_wmem=0 → err[4]=1. A_wmem=15 → no error. Then assert reset → err=0 and all CEN outputs=1.
- Build without the macro and repeat the second scenario → err stays 0 and decoded strobes still match `inst` delayed by 1 cycle.
